// File: rtl/bram_port_arbiter.sv
// -----------------------------------------------------------------------------
// bram_port_arbiter
//
// Shares port A of one RAMB36E1 between two requesters (m0, m1) with
// round-robin arbitration. After every reset the whole RAM is zero-filled.
// After that, single-word read/write requests are accepted with a
// valid/ready handshake. Read data returns to the requester that issued the
// read, after a fixed latency.
//
// Handshake: a request transfers on a rising edge where valid && ready are
// both 1. A requester holds valid and its payload (we/addr/wdata) stable
// until that edge. Ready is a combinational function of the two valids, the
// round-robin pointer and the FSM state, and never depends on ready itself.
// Responses have no backpressure: rsp_valid is a one-cycle pulse, and
// rsp_rdata is meaningful only while rsp_valid is 1.
//
// Parameters
//   ADDR_W  word-address width, depth = 2**ADDR_W
//   DATA_W  data width, multiple of 8
//   DO_REG  0: read latency 1, 1: latency 2 (must match the primitive DOA_REG)
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   m{0,1}_valid/_ready         request handshake
//   m{0,1}_we/_addr/_wdata      request payload (we=1 write, 0 read)
//   m{0,1}_rsp_valid/_rsp_rdata read response
//   init_done                   zero-fill finished
//   ram_en/_we/_addr/_din       to ENARDEN / WEA / ADDRARDADDR / DIADI
//   ram_regce                   to REGCEAREGCE
//   ram_dout                    from DOADO
//   dbg_state                   current FSM state (0 idle, 1 init, 2 run)
// -----------------------------------------------------------------------------
module bram_port_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int DO_REG = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  m0_valid,
    output logic                  m0_ready,
    input  logic                  m0_we,
    input  logic [ADDR_W-1:0]     m0_addr,
    input  logic [DATA_W-1:0]     m0_wdata,
    output logic                  m0_rsp_valid,
    output logic [DATA_W-1:0]     m0_rsp_rdata,

    input  logic                  m1_valid,
    output logic                  m1_ready,
    input  logic                  m1_we,
    input  logic [ADDR_W-1:0]     m1_addr,
    input  logic [DATA_W-1:0]     m1_wdata,
    output logic                  m1_rsp_valid,
    output logic [DATA_W-1:0]     m1_rsp_rdata,

    output logic                  init_done,

    output logic                  ram_en,
    output logic [DATA_W/8-1:0]   ram_we,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W-1:0]     ram_din,
    output logic                  ram_regce,
    input  logic [DATA_W-1:0]     ram_dout,

    output logic [1:0]            dbg_state
);

    localparam int WE_W = DATA_W / 8;
    localparam logic [ADDR_W-1:0] CNT_LAST = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [ADDR_W-1:0]   r_init_cnt;
    logic                r_init_done;
    logic                r_rr_ptr;      // 0: m0 wins a tie, 1: m1 wins a tie

    logic                w_gnt0;
    logic                w_gnt1;
    logic                w_gnt_any;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;

    logic                r_ram_en;
    logic [WE_W-1:0]     r_ram_we;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic [DATA_W-1:0]   r_ram_din;

    // Tag pipeline: stage 0 is valid in the cycle the RAM sees the access,
    // stage DO_REG in the last cycle before read data is on ram_dout.
    logic [DO_REG:0]     r_tag_rd;
    logic [DO_REG:0]     r_tag_id;

    logic                r_rsp_valid0;
    logic                r_rsp_valid1;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state. IDLE lasts exactly one cycle after reset release.
    // INIT ends on the edge that loads the last address.
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = S_INIT;
            S_INIT:  if (r_init_cnt == CNT_LAST) w_state_nxt = S_RUN;
            S_RUN:   w_state_nxt = S_RUN;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs (grant / ready). Grants start only once init_done is
    // visible, so no request can overlap the final zero-fill write.
    // -------------------------------------------------------------------------
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (r_state == S_RUN && r_init_done) begin
            if (m0_valid && (!m1_valid || !r_rr_ptr)) begin
                w_gnt0 = 1'b1;
            end else if (m1_valid) begin
                w_gnt1 = 1'b1;
            end
        end
    end

    assign w_gnt_any   = w_gnt0 | w_gnt1;
    assign w_sel_we    = w_gnt1 ? m1_we    : m0_we;
    assign w_sel_addr  = w_gnt1 ? m1_addr  : m0_addr;
    assign w_sel_wdata = w_gnt1 ? m1_wdata : m0_wdata;

    // -------------------------------------------------------------------------
    // RAM port registers and zero-fill counter. Before RUN the port writes
    // zero at the counter address every cycle; the first write is loaded on
    // the edge that leaves IDLE.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ram_en   <= 1'b0;
            r_ram_we   <= '0;
            r_ram_addr <= '0;
            r_ram_din  <= '0;
            r_init_cnt <= '0;
        end else if (r_state != S_RUN) begin
            r_ram_en   <= 1'b1;
            r_ram_we   <= '1;
            r_ram_addr <= r_init_cnt;
            r_ram_din  <= '0;
            r_init_cnt <= r_init_cnt + 1'b1;
        end else begin
            r_ram_en <= w_gnt_any;
            r_ram_we <= {WE_W{w_gnt_any & w_sel_we}};
            if (w_gnt_any) begin
                r_ram_addr <= w_sel_addr;
                r_ram_din  <= w_sel_wdata;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Arbitration pointer, init_done, tag pipeline and response pulses.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_init_done  <= 1'b0;
            r_rr_ptr     <= 1'b0;
            r_tag_rd     <= '0;
            r_tag_id     <= '0;
            r_rsp_valid0 <= 1'b0;
            r_rsp_valid1 <= 1'b0;
        end else begin
            r_init_done <= (r_state == S_RUN);

            // After a grant the other side gets priority on the next tie.
            if (w_gnt0) begin
                r_rr_ptr <= 1'b1;
            end else if (w_gnt1) begin
                r_rr_ptr <= 1'b0;
            end

            r_tag_rd[0] <= w_gnt_any & ~w_sel_we;
            r_tag_id[0] <= w_gnt1;
            for (int k = 1; k <= DO_REG; k++) begin
                r_tag_rd[k] <= r_tag_rd[k-1];
                r_tag_id[k] <= r_tag_id[k-1];
            end

            r_rsp_valid0 <= r_tag_rd[DO_REG] & ~r_tag_id[DO_REG];
            r_rsp_valid1 <= r_tag_rd[DO_REG] &  r_tag_id[DO_REG];
        end
    end

    // With the output register enabled, it must capture in the cycle after
    // the array access; stage 1 of the tag pipeline marks exactly that cycle.
    generate
        if (DO_REG != 0) begin : g_regce
            assign ram_regce = r_tag_rd[DO_REG];
        end else begin : g_no_regce
            assign ram_regce = 1'b0;
        end
    endgenerate

    assign m0_ready     = w_gnt0;
    assign m1_ready     = w_gnt1;
    assign m0_rsp_valid = r_rsp_valid0;
    assign m1_rsp_valid = r_rsp_valid1;
    // Only one requester is told the data is valid, so both can share DOADO.
    assign m0_rsp_rdata = ram_dout;
    assign m1_rsp_rdata = ram_dout;

    assign init_done = r_init_done;
    assign ram_en    = r_ram_en;
    assign ram_we    = r_ram_we;
    assign ram_addr  = r_ram_addr;
    assign ram_din   = r_ram_din;
    assign dbg_state = r_state;

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares a single RAMB36E1 port between two requesters (m0, m1) using round-robin arbitration.
- After every reset it zero-fills the whole RAM, then serves read and write requests with a valid/ready handshake.
- Read data is returned to whichever requester issued the read, with fixed latency.
- Sits between fuzzer/minitest stimulus logic and the BRAM primitive. It drives the primitive's port-A pins: ENARDEN, WEA, ADDRARDADDR, DIADI, REGCEAREGCE, DOADO.

Parameters:
- ADDR_W, 10, RAM word-address width; depth = 2**ADDR_W words.
- DATA_W, 32, data width; must be a multiple of 8.
- DO_REG, 0, BRAM output register: 0 gives read latency 1, 1 gives latency 2. Must match the primitive's DOA_REG.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- m0_valid, m1_valid  in  1 each  request valid.
- m0_ready, m1_ready  out  1 each  request accepted this cycle (combinational).
- m0_we, m1_we  in  1 each  1 = write, 0 = read.
- m0_addr, m1_addr  in  ADDR_W each  word address.
- m0_wdata, m1_wdata  in  DATA_W each  write data.
- m0_rsp_valid, m1_rsp_valid  out  1 each  read data valid (single-cycle pulse).
- m0_rsp_rdata, m1_rsp_rdata  out  DATA_W each  read data.
- init_done  out  1  zero-fill complete.
- ram_en  out  1  to ENARDEN.
- ram_we  out  DATA_W/8  to WEA; all bits equal.
- ram_addr  out  ADDR_W  to ADDRARDADDR.
- ram_din  out  DATA_W  to DIADI.
- ram_regce  out  1  to REGCEAREGCE.
- ram_dout  in  DATA_W  from DOADO.

Behaviour:
- Reset (async assert, synchronous release):
  - ram_en, ram_we, ram_regce, init_done, m*_ready, m*_rsp_valid all 0.
  - ram_addr and ram_din are 0; the init counter is 0; the round-robin pointer points at m0.
  - All in-flight tags are cleared.
- FSM state INIT (entered on the first clock after reset release):
  - Each cycle, registered outputs drive ram_en=1, ram_we all 1s, ram_din=0, ram_addr=counter.
  - The counter increments by 1 per cycle.
  - After address 2**ADDR_W-1 is written, the FSM moves to RUN and init_done goes to 1 in the following cycle.
  - m*_ready stays 0 throughout INIT.
- FSM state RUN, arbitration:
  - Only one of m0_ready/m1_ready is 1 per cycle; ready is asserted only to a requester whose valid is 1.
  - Only one valid: that requester is granted.
  - Both valid: the pointer side is granted. After any grant the pointer moves to the other requester; with no grant it holds.
  - Handshake completes when valid && ready at the rising edge.
  - Requesters hold valid and payload stable until accepted; ready never depends on ready.
- Issue:
  - A request accepted at edge N drives ram_en=1 during cycle N+1 (registered), with ram_addr/ram_din from the request.
  - For a write, ram_we is all 1s; for a read, ram_we is 0.
  - With no grant at edge N, ram_en=0 and ram_we=0 in cycle N+1.
- Read return:
  - A tag pipeline of depth 1+DO_REG records {is_read, requester}.
  - With DO_REG=0: that requester's rsp_valid=1 in cycle N+2, with rsp_rdata=ram_dout in the same cycle.
  - With DO_REG=1: ram_regce=1 in cycle N+2 and rsp_valid=1 in cycle N+3.
  - With DO_REG=0, ram_regce is held 0.
  - Writes generate no response.
- Response interface:
  - No backpressure on responses.
  - Throughput is one request per cycle sustained, and responses stay in issue order.
  - rsp_rdata is only meaningful while rsp_valid=1. It may drive ram_dout to both requesters unconditionally.
- Write-then-read to the same address in back-to-back cycles must return the new data (port-A access is sequential).
- Reset asserted mid-operation: all outputs return to their reset values immediately, pending reads are dropped with no response, and INIT restarts from address 0 after release.

Test Plan:
- Reset release with ADDR_W=4 -> ram_en=1 and ram_we all 1s for exactly 16 consecutive cycles with ram_addr 0..15, then init_done=1 in the next cycle; m*_ready=0 throughout.
- After init, m0 writes 0xDEADBEEF to addr 3, then reads addr 3 (DO_REG=0) -> m0_rsp_valid pulses exactly 2 cycles after read acceptance with rdata 0xDEADBEEF; m1_rsp_valid stays 0.
- m0 and m1 both hold valid reads for 4 cycles -> grants alternate m0, m1, m0, m1; responses return to the matching requester in order.
- Read of never-written addr 7 after init -> rdata 0x00000000.
- DO_REG=1, m1 reads addr 5 holding 0x12345678 -> ram_regce=1 at acceptance+2, m1_rsp_valid at acceptance+3 with 0x12345678.
- Reset asserted the cycle after a read is accepted -> no rsp_valid ever appears for that read; INIT restarts at address 0 after release.
